seq_rec_sbus: RTL and testbench

Sequence recorder: the capture-side counterpart of the sequence generator. It samples an IN_BITS-wide parallel input every BUS_CLK cycle into on-chip memory after a software or external start, then exposes status and the captured samples on the 8-bit sbus register interface. It shares one clock domain with the bus; there is no separate sequence clock.

---
 rtl/seq_rec_pkg.sv | 23 ++
 rtl/seq_rec_core.sv | 91 +++++++++
 rtl/seq_rec_sbus.sv | 117 +++++++++++
 tb/tb_seq_rec_sbus.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_rec_pkg.sv
// seq_rec_pkg: shared register map, version and FSM encoding
// for the sequence recorder.
package seq_rec_pkg;

    localparam logic [15:0] REG_RESET   = 16'h0000;
    localparam logic [15:0] REG_START   = 16'h0001;
    localparam logic [15:0] REG_CONF    = 16'h0002;
    localparam logic [15:0] REG_COUNT_L = 16'h0003;
    localparam logic [15:0] REG_COUNT_H = 16'h0004;
    localparam logic [15:0] REG_CAPT_L  = 16'h0005;
    localparam logic [15:0] REG_CAPT_H  = 16'h0006;
    localparam logic [15:0] MEM_OFFSET  = 16'h0010;

    localparam logic [7:0] VERSION = 8'd1;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DONE
    } state_t;

endpackage

// File: rtl/seq_rec_core.sv
// seq_rec_core: capture FSM, sample counter and sample memory.
// Bus agnostic; the front end supplies strobes and a read address.
module seq_rec_core
    import seq_rec_pkg::*;
#(
    parameter int IN_BITS = 8,
    parameter int DEPTH   = 8192,
    parameter int AW      = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               soft_rst,
    input  logic               start,
    input  logic               ext_start,
    input  logic               en_ext_start,
    input  logic [15:0]        count,
    input  logic [IN_BITS-1:0] seq_in,
    input  logic [AW-1:0]      rd_addr,
    output logic [IN_BITS-1:0] rd_data,
    output logic               ready,
    output logic [15:0]        captured
);

    localparam int CW = $clog2(DEPTH + 1);

    state_t             state;
    logic [CW-1:0]      capt;
    logic [CW-1:0]      cnt_eff;
    logic [CW-1:0]      eff;
    logic               store;
    logic [IN_BITS-1:0] mem [DEPTH];

    // A zero or oversized request means "fill the whole memory".
    always_comb begin
        eff = CW'(DEPTH);
        if (count != '0 && 32'(count) <= DEPTH)
            eff = CW'(count);
    end

    assign store    = (state == CAPTURE) && !soft_rst;
    assign captured = 16'(capt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ready   <= 1'b1;
            capt    <= '0;
            cnt_eff <= '0;
        end else if (soft_rst) begin
            state <= IDLE;
            ready <= 1'b1;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        cnt_eff <= eff;
                        ready   <= 1'b0;
                        if (en_ext_start) begin
                            state <= ARMED;
                        end else begin
                            state <= CAPTURE;
                            capt  <= '0;
                        end
                    end
                end
                ARMED: begin
                    if (ext_start) begin
                        state <= CAPTURE;
                        capt  <= '0;
                    end
                end
                CAPTURE: begin
                    capt <= capt + 1'b1;
                    if (capt == cnt_eff - 1'b1) begin
                        state <= DONE;
                        ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read-before-write: a bus read sees the contents before this edge.
    always_ff @(posedge clk) begin
        if (store)
            mem[capt[AW-1:0]] <= seq_in;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/seq_rec_sbus.sv
// seq_rec_sbus: sbus register front end for the sequence recorder.
// Decodes the register map and drives the two-stage registered read path.
module seq_rec_sbus
    import seq_rec_pkg::*;
#(
    parameter int                   ABUSWIDTH = 16,
    parameter logic [ABUSWIDTH-1:0] BASEADDR  = '0,
    parameter logic [ABUSWIDTH-1:0] HIGHADDR  = '0,
    parameter int                   MEM_BYTES = 8192,
    parameter int                   IN_BITS   = 8
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    input  logic [7:0]           BUS_DATA_IN,
    output logic [7:0]           BUS_DATA_OUT,
    input  logic                 BUS_RD,
    input  logic                 BUS_WR,
    input  logic                 SEQ_EXT_START,
    input  logic [IN_BITS-1:0]   SEQ_IN
);

    localparam int BPS   = IN_BITS / 8;
    localparam int DEPTH = MEM_BYTES / BPS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ABUSWIDTH-1:0] SPAN = HIGHADDR - BASEADDR;

    logic [ABUSWIDTH-1:0] offset;
    logic [15:0]          off, moff, off_q;
    logic                 wr, rd, is_mem, rd_q, mem_q;
    logic [1:0]           bsel, bsel_q;
    logic [AW-1:0]        mem_addr;
    logic                 en_ext_start, ready;
    logic [15:0]          count, captured;
    logic [IN_BITS-1:0]   mem_word;
    logic [7:0]           rd_mux;

    // Below-base addresses wrap to a large offset and fall outside SPAN.
    assign offset   = BUS_ADD - BASEADDR;
    assign off      = 16'(offset);
    assign wr       = BUS_WR && (offset <= SPAN);
    assign rd       = BUS_RD && (offset <= SPAN);
    assign is_mem   = (off >= MEM_OFFSET) &&
                      (32'(off) < 32'(MEM_OFFSET) + MEM_BYTES);
    assign moff     = off - MEM_OFFSET;
    assign bsel     = 2'(moff % 16'(BPS));
    assign mem_addr = AW'(moff / 16'(BPS));

    seq_rec_core #(
        .IN_BITS (IN_BITS),
        .DEPTH   (DEPTH),
        .AW      (AW)
    ) u_core (
        .clk          (BUS_CLK),
        .rst          (BUS_RST),
        .soft_rst     (wr && off == REG_RESET),
        .start        (wr && off == REG_START),
        .ext_start    (SEQ_EXT_START),
        .en_ext_start (en_ext_start),
        .count        (count),
        .seq_in       (SEQ_IN),
        .rd_addr      (mem_addr),
        .rd_data      (mem_word),
        .ready        (ready),
        .captured     (captured)
    );

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            en_ext_start <= 1'b0;
            count        <= '0;
        end else if (wr) begin
            case (off)
                REG_CONF:    en_ext_start <= BUS_DATA_IN[0];
                REG_COUNT_L: count[7:0]   <= BUS_DATA_IN;
                REG_COUNT_H: count[15:8]  <= BUS_DATA_IN;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            off_q == REG_RESET:   rd_mux = VERSION;
            off_q == REG_START:   rd_mux = {7'b0, ready};
            off_q == REG_CONF:    rd_mux = {7'b0, en_ext_start};
            off_q == REG_COUNT_L: rd_mux = count[7:0];
            off_q == REG_COUNT_H: rd_mux = count[15:8];
            off_q == REG_CAPT_L:  rd_mux = captured[7:0];
            off_q == REG_CAPT_H:  rd_mux = captured[15:8];
            mem_q:                rd_mux = 8'(mem_word >> {bsel_q, 3'b000});
            default:              rd_mux = '0;
        endcase
    end

    // Stage 1 latches the decoded read, stage 2 updates the output.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            rd_q         <= 1'b0;
            mem_q        <= 1'b0;
            off_q        <= '0;
            bsel_q       <= '0;
            BUS_DATA_OUT <= '0;
        end else begin
            rd_q <= rd;
            if (rd) begin
                off_q  <= off;
                mem_q  <= is_mem;
                bsel_q <= bsel;
            end
            if (rd_q)
                BUS_DATA_OUT <= rd_mux;
        end
    end

endmodule

// File: tb/tb_seq_rec_sbus.sv
// tb_seq_rec_sbus: table vectors, hand sequences and randomized captures
// checked against an input-history model of the recorder.
module tb_seq_rec_sbus;
    import seq_rec_pkg::*;

    localparam logic [15:0] B8  = 16'h1000;
    localparam logic [15:0] B16 = 16'h2000;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bus_add = '0;
    logic [7:0]  bus_din = '0;
    logic [7:0]  dout8, dout16;
    logic        bus_rd = 1'b0;
    logic        bus_wr = 1'b0;
    logic        ext = 1'b0;
    logic [7:0]  seq8 = '0;
    logic [15:0] seq16 = '0;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    bit rand_seq = 1'b0;
    logic [7:0]  hist8  [int];
    logic [15:0] hist16 [int];

    seq_rec_sbus #(
        .ABUSWIDTH (16),
        .BASEADDR  (16'h1000),
        .HIGHADDR  (16'h104F),
        .MEM_BYTES (64),
        .IN_BITS   (8)
    ) dut8 (
        .BUS_CLK       (clk),
        .BUS_RST       (rst),
        .BUS_ADD       (bus_add),
        .BUS_DATA_IN   (bus_din),
        .BUS_DATA_OUT  (dout8),
        .BUS_RD        (bus_rd),
        .BUS_WR        (bus_wr),
        .SEQ_EXT_START (ext),
        .SEQ_IN        (seq8)
    );

    seq_rec_sbus #(
        .ABUSWIDTH (16),
        .BASEADDR  (16'h2000),
        .HIGHADDR  (16'h210F),
        .MEM_BYTES (256),
        .IN_BITS   (16)
    ) dut16 (
        .BUS_CLK       (clk),
        .BUS_RST       (rst),
        .BUS_ADD       (bus_add),
        .BUS_DATA_IN   (bus_din),
        .BUS_DATA_OUT  (dout16),
        .BUS_RD        (bus_rd),
        .BUS_WR        (bus_wr),
        .SEQ_EXT_START (ext),
        .SEQ_IN        (seq16)
    );

    always #5 clk = ~clk;

    // Input history: the value of SEQ_IN seen at each rising edge.
    always @(posedge clk) begin
        hist8[cyc]  = seq8;
        hist16[cyc] = seq16;
        cyc = cyc + 1;
    end

    always @(negedge clk)
        if (rand_seq) seq8 = 8'($urandom);

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic wr_e(input logic [15:0] a, input logic [7:0] d,
                        output int e);
        @(negedge clk);
        bus_add = a;
        bus_din = d;
        bus_wr  = 1'b1;
        @(negedge clk);
        bus_wr = 1'b0;
        e = cyc - 1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        int e;
        wr_e(a, d, e);
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk);
        bus_add = a;
        bus_rd  = 1'b1;
        @(negedge clk);
        bus_rd = 1'b0;
        @(negedge clk);
        d = (a >= B16) ? dout16 : dout8;
    endtask

    task automatic rd_chk(input string name, input logic [15:0] a,
                          input logic [7:0] exp);
        logic [7:0] d;
        rd(a, d);
        check(name, d, exp);
    endtask

    task automatic wait_ready(input logic [15:0] base, input string name);
        logic [7:0] d;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            rd(base + REG_START, d);
            ok = d[0];
        end
        check(name, 32'(ok), 32'd1);
    endtask

    // Random capture on the 8-bit recorder, checked against the history.
    task automatic run8(input int id, input int cnt, input bit use_ext);
        int n, c;
        c = (cnt == 0 || cnt > 64) ? 64 : cnt;
        wr(B8 + REG_CONF, {7'b0, use_ext});
        wr(B8 + REG_COUNT_L, 8'(cnt));
        wr(B8 + REG_COUNT_H, 8'(cnt >> 8));
        rand_seq = 1'b1;
        wr_e(B8 + REG_START, 8'h00, n);
        if (use_ext) begin
            repeat ($urandom_range(1, 6)) @(negedge clk);
            ext = 1'b1;
            @(negedge clk);
            ext = 1'b0;
            n = cyc - 1;
        end
        wait_ready(B8, $sformatf("run%0d ready", id));
        rand_seq = 1'b0;
        rd_chk($sformatf("run%0d captL", id), B8 + REG_CAPT_L, 8'(c));
        rd_chk($sformatf("run%0d captH", id), B8 + REG_CAPT_H, 8'(c >> 8));
        for (int k = 0; k < c; k++)
            rd_chk($sformatf("run%0d mem[%0d]", id, k),
                   B8 + MEM_OFFSET + 16'(k), hist8[n + 1 + k]);
        rd_chk($sformatf("run%0d captL hold", id), B8 + REG_CAPT_L, 8'(c));
    endtask

    initial begin
        vec_t rst_tab [10];
        vec_t w16_tab [4];
        logic [7:0] d;
        int n, s, e;

        rst_tab[0] = '{B8 + 16'h00, 8'h01};
        rst_tab[1] = '{B8 + 16'h01, 8'h01};
        rst_tab[2] = '{B8 + 16'h02, 8'h00};
        rst_tab[3] = '{B8 + 16'h03, 8'h00};
        rst_tab[4] = '{B8 + 16'h04, 8'h00};
        rst_tab[5] = '{B8 + 16'h05, 8'h00};
        rst_tab[6] = '{B8 + 16'h06, 8'h00};
        rst_tab[7] = '{B8 + 16'h07, 8'h00};
        rst_tab[8] = '{B8 + 16'h0F, 8'h00};
        rst_tab[9] = '{B16 + 16'h01, 8'h01};
        w16_tab[0] = '{B16 + 16'h10, 8'h34};
        w16_tab[1] = '{B16 + 16'h11, 8'h12};
        w16_tab[2] = '{B16 + 16'h12, 8'hCD};
        w16_tab[3] = '{B16 + 16'h13, 8'hAB};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset dout", dout8, 8'h00);
        foreach (rst_tab[i])
            rd_chk($sformatf("reset reg %0h", rst_tab[i].addr),
                   rst_tab[i].addr, rst_tab[i].exp);

        // COUNT=4 ramp, READY polled with back-to-back reads.
        wr(B8 + REG_COUNT_L, 8'd4);
        wr_e(B8 + REG_START, 8'h00, n);
        seq8    = 8'hA0;
        bus_add = B8 + REG_START;
        bus_rd  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seq8 = seq8 + 8'd1;
            e = cyc - 2;
            if (e >= n + 1)
                check($sformatf("ramp ready e%0d", e - n), dout8,
                      {7'b0, !(e >= n && e < n + 4)});
        end
        bus_rd = 1'b0;
        rd_chk("ramp captL", B8 + REG_CAPT_L, 8'd4);
        for (int k = 0; k < 4; k++)
            rd_chk($sformatf("ramp mem[%0d]", k), B8 + MEM_OFFSET + 16'(k),
                   8'hA0 + 8'(k));

        // External trigger path.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wr(B8 + REG_CONF, 8'h01);
        wr(B8 + REG_COUNT_L, 8'd8);
        seq8 = 8'h55;
        wr(B8 + REG_START, 8'h00);
        repeat (20) @(negedge clk);
        rd_chk("armed ready", B8 + REG_START, 8'h00);
        rd_chk("armed capt", B8 + REG_CAPT_L, 8'h00);
        ext = 1'b1;
        @(negedge clk);
        ext = 1'b0;
        wait_ready(B8, "ext ready");
        rd_chk("ext captL", B8 + REG_CAPT_L, 8'd8);
        for (int k = 0; k < 8; k++)
            rd_chk($sformatf("ext mem[%0d]", k), B8 + MEM_OFFSET + 16'(k),
                   8'h55);

        // 16-bit samples, little-endian byte layout.
        wr(B16 + REG_COUNT_L, 8'd2);
        wr_e(B16 + REG_START, 8'h00, n);
        seq16 = 16'h1234;
        @(negedge clk);
        seq16 = 16'hABCD;
        @(negedge clk);
        wait_ready(B16, "w16 ready");
        foreach (w16_tab[i])
            rd_chk($sformatf("w16 byte %0d", i), w16_tab[i].addr,
                   w16_tab[i].exp);

        // Soft reset in the middle of a 100-sample capture.
        wr(B16 + REG_COUNT_L, 8'd100);
        seq16 = 16'h0100;
        wr_e(B16 + REG_START, 8'h00, n);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            seq16 = 16'h0100 + 16'(i);
        end
        wr_e(B16 + REG_RESET, 8'h00, s);
        bus_add = B16 + REG_START;
        bus_rd  = 1'b1;
        @(negedge clk);
        bus_rd = 1'b0;
        @(negedge clk);
        check("srst ready", dout16, 8'h01);
        rd_chk("srst captL", B16 + REG_CAPT_L, 8'(s - n - 1));
        repeat (10) @(negedge clk);
        rd_chk("srst captL hold", B16 + REG_CAPT_L, 8'(s - n - 1));
        rd_chk("srst count kept", B16 + REG_COUNT_L, 8'd100);
        rd_chk("srst mem b0", B16 + 16'h10, 8'h00);
        rd_chk("srst mem b1", B16 + 16'h11, 8'h01);
        wr(B16 + REG_COUNT_L, 8'd3);
        seq16 = 16'hBEEF;
        wr(B16 + REG_START, 8'h00);
        wait_ready(B16, "restart ready");
        rd_chk("restart captL", B16 + REG_CAPT_L, 8'd3);
        rd_chk("restart b0", B16 + 16'h10, 8'hEF);
        rd_chk("restart b1", B16 + 16'h11, 8'hBE);
        rd_chk("restart b6 old", B16 + 16'h16, 8'h03);

        // COUNT=0 fills all 64 bytes without wrapping, then random runs.
        run8(0, 0, 1'b0);
        for (int r = 1; r <= 5; r++)
            run8(r, $urandom_range(0, 80), 1'($urandom_range(0, 1)));
        run8(6, 70, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
